cphy_symbol_deserializer: RTL
=============================

// Module: cphy_symbol_deserializer
// PURPOSE
//   Slave-side C-PHY stage that sits directly upstream of the 7-wide word register.
//   Takes one decoded 3-bit symbol per accepted beat and hunts for the sync word.
//   Once aligned, packs every 7 consecutive symbols into one 21-bit group.
//   Each group is presented with a single-cycle valid pulse for capture downstream.
// PARAMETERS
//   SYMS      7             symbols per word group (C-PHY 7-symbol / 16-bit mapping)
//   SYNC_WORD 21'o3444443   sync pattern, 3 bits per symbol, first-received in [20:18]
// PORTS
//   clk         in   1   system clock, all logic on rising edge
//   rst_n       in   1   asynchronous active-low reset
//   rx_active   in   1   high while an HS burst is being received
//   sym_in      in   3   decoded symbol value, legal range 0..4
//   sym_valid   in   1   sym_in is valid this cycle (accepted only when rx_active=1)
//   word_out    out  21  packed group: first symbol in [20:18], last symbol in [2:0]
//   word_valid  out  1   one-cycle pulse, word_out holds a new group
//   sync_det    out  1   one-cycle pulse, sync word found
//   aligned     out  1   level, high in ALIGNED state
//   sym_err     out  1   one-cycle pulse, accepted symbol was > 4
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - all outputs 0, state=HUNT
//     - history, accumulator and count cleared
//   Accept condition: acc = sym_valid & rx_active. No state changes without acc, except the rx_active exit.
//   HUNT:
//     - on acc, hist <= {hist[14:0], sym_in} (18-bit, last 6 symbols)
//     - match = acc & ({hist, sym_in} == SYNC_WORD)
//     - on match: next cycle aligned=1 and sync_det=1 for one cycle; count=0
//     - sync symbols are not emitted as data
//   ALIGNED:
//     - on acc with count<SYMS-1: acc_reg <= {acc_reg[14:0], sym_in}; count++
//     - on acc with count==SYMS-1: word_out <= {acc_reg, sym_in}; word_valid=1 next cycle; count wraps to 0
//     - no sync re-detection while ALIGNED (payload may mimic the pattern)
//     - latency: last symbol accepted in cycle N -> word_valid=1 in cycle N+1
//     - back-to-back symbols -> word_valid every 7 cycles
//   word_out holds its value between pulses; it is not cleared except by reset.
//   rx_active=0 in any state:
//     - next cycle state=HUNT, aligned=0, count=0, hist/acc_reg cleared
//     - a partial group is discarded with no word_valid
//     - a sym_valid in that same cycle is ignored
//   sym_err:
//     - pulses in the cycle after an accepted symbol with sym_in>4
//     - the symbol is still shifted or packed as received
//   Gaps (sym_valid=0 while rx_active=1) stall count and history without loss.
//   rst_n assertion mid-group: immediate clear, with no partial word output.
// TESTING
//   1. Reset, rx_active=1, feed 3,4,4,4,4,4,3 -> sync_det pulse + aligned=1 one cycle after the 7th symbol.
//   2. After sync, feed 0,1,2,3,4,0,1 back-to-back -> word_valid one cycle after the last symbol;
//      word_out=21'o0123401; no further pulse until 7 more symbols.
//   3. Aligned, 3 symbols, then rx_active=0 -> aligned=0 next cycle, no word_valid;
//      re-sync and a full group -> correct word with no stale symbols.
//   4. Aligned, feed 3,4,4,4,4,4,3 as payload -> word_valid, word_out=21'o3444443, no sync_det.
//   5. Aligned, symbol 7 inside a group, plus sym_valid gaps of 1-3 cycles -> one sym_err pulse;
//      word_out contains octal digit 7 in that position; word_valid only after 7 accepted symbols.
//   6. HUNT, stream 3,4,4,3,4,4,4,4,4,3 -> sync_det only after the final 3;
//      rst_n low mid-group -> all outputs 0 immediately.

Source files
------------

// File: rtl/cphy_symbol_deserializer.sv
// C-PHY slave symbol deserializer: hunts for the sync word, then packs
// every SYMS accepted symbols into one group with a single-cycle valid.
module cphy_symbol_deserializer #(
   parameter int          SYMS      = 7,
   parameter logic [20:0] SYNC_WORD = 21'o3444443
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx_active,
   input  logic [2:0]          sym_in,
   input  logic                sym_valid,
   output logic [3*SYMS-1:0]   word_out,
   output logic                word_valid,
   output logic                sync_det,
   output logic                aligned,
   output logic                sym_err
);

   localparam int W  = 3 * SYMS;
   localparam int HW = W - 3;
   localparam int CW = $clog2(SYMS);
   localparam logic [CW-1:0] LAST = CW'(SYMS - 1);

   typedef enum logic {HUNT, ALIGNED} state_t;

   state_t          state, state_n;
   logic [HW-1:0]   hist, hist_n;
   logic [HW-1:0]   acc_reg, acc_reg_n;
   logic [CW-1:0]   count, count_n;
   logic [W-1:0]    word_n;
   logic            word_valid_n;
   logic            sync_det_n;
   logic            sym_err_n;
   logic            acc;

   assign acc     = sym_valid & rx_active;
   assign aligned = (state == ALIGNED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         hist       <= '0;
         acc_reg    <= '0;
         count      <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         sync_det   <= 1'b0;
         sym_err    <= 1'b0;
      end else begin
         state      <= state_n;
         hist       <= hist_n;
         acc_reg    <= acc_reg_n;
         count      <= count_n;
         word_out   <= word_n;
         word_valid <= word_valid_n;
         sync_det   <= sync_det_n;
         sym_err    <= sym_err_n;
      end
   end

   always_comb begin
      state_n      = state;
      hist_n       = hist;
      acc_reg_n    = acc_reg;
      count_n      = count;
      word_n       = word_out;
      word_valid_n = 1'b0;
      sync_det_n   = 1'b0;
      sym_err_n    = acc & (sym_in > 3'd4);

      // Burst end drops any partial group and forces a fresh hunt.
      if (!rx_active) begin
         state_n   = HUNT;
         hist_n    = '0;
         acc_reg_n = '0;
         count_n   = '0;
      end else if (acc) begin
         unique case (state)
            HUNT: begin
               if ({hist, sym_in} == SYNC_WORD) begin
                  state_n    = ALIGNED;
                  sync_det_n = 1'b1;
                  count_n    = '0;
                  hist_n     = '0;
                  acc_reg_n  = '0;
               end else begin
                  hist_n = {hist[HW-4:0], sym_in};
               end
            end
            ALIGNED: begin
               if (count == LAST) begin
                  word_n       = {acc_reg, sym_in};
                  word_valid_n = 1'b1;
                  count_n      = '0;
               end else begin
                  acc_reg_n = {acc_reg[HW-4:0], sym_in};
                  count_n   = count + 1'b1;
               end
            end
            default: state_n = HUNT;
         endcase
      end
   end

endmodule
